// File: rtl/simon_game_multi.sv
// Parametrised Simon memory game: LFSR-drawn pattern, replay/verify rounds, win/lose flags.
// Optional player timeout in WAIT_PLAYER is enabled by defining SIMON_TIMEOUT_EN.
module simon_game_multi #(
  parameter int NUM_CH       = 4,
  parameter int GAME_LIMIT   = 6,
  parameter int CLKS_PER_SEC = 25000000,
  parameter int TIMEOUT_SECS = 3
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_LED,
  output logic [7:0]        o_Score,
  output logic              o_Win,
  output logic              o_Lose
);
  localparam int CH_W  = $clog2(NUM_CH);
  // One counter serves both the display period and the (longer) player timeout.
  localparam int TMR_W = $clog2(TIMEOUT_SECS * CLKS_PER_SEC + 1);
  localparam logic [TMR_W-1:0] CLK_LAST = TMR_W'(CLKS_PER_SEC - 1);
`ifdef SIMON_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(TIMEOUT_SECS * CLKS_PER_SEC - 1);
`endif

  typedef enum logic [2:0] {
    IDLE, START, PAT_OFF, PAT_SHOW, WAIT_PLAYER, INCR, WIN, LOSE
  } state_t;

  state_t            state, state_next;
  logic [21:0]       lfsr;
  logic [NUM_CH-1:0] sw_prev;
  logic [7:0]        score, score_next;
  logic [7:0]        index, index_next;
  logic [TMR_W-1:0]  tmr, tmr_next;
  logic [CH_W-1:0]   pattern  [GAME_LIMIT];
  logic [CH_W-1:0]   pat_load [GAME_LIMIT];
  logic [CH_W-1:0]   cur_ch;
  logic [NUM_CH-1:0] exp_oh;
  logic [NUM_CH-1:0] press;
  logic              press_any;
  logic              start_combo;

  assign press       = i_Switch & ~sw_prev;
  assign press_any   = |press;
  assign start_combo = i_Switch[0] & i_Switch[1];

  // Entry k takes CH_W LFSR bits starting at CH_W*k, wrapping around bit 21.
  for (genvar gi = 0; gi < GAME_LIMIT; gi++) begin : gen_pat_load
    for (genvar gb = 0; gb < CH_W; gb++) begin : gen_bit
      assign pat_load[gi][gb] = lfsr[(CH_W * gi + gb) % 22];
    end
  end

  always_comb begin
    cur_ch = '0;
    for (int k = 0; k < GAME_LIMIT; k++) begin
      if (index == 8'(k)) cur_ch = pattern[k];
    end
    exp_oh         = '0;
    exp_oh[cur_ch] = 1'b1;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state   <= IDLE;
      lfsr    <= 22'h000001;
      sw_prev <= '0;
      score   <= '0;
      index   <= '0;
      tmr     <= '0;
    end else begin
      state   <= state_next;
      lfsr    <= {lfsr[20:0], ~(lfsr[21] ^ lfsr[20])};
      sw_prev <= i_Switch;
      score   <= score_next;
      index   <= index_next;
      tmr     <= tmr_next;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int k = 0; k < GAME_LIMIT; k++) pattern[k] <= '0;
    end else if (state == START) begin
      for (int k = 0; k < GAME_LIMIT; k++) pattern[k] <= pat_load[k];
    end
  end

  always_comb begin
    state_next = state;
    score_next = score;
    index_next = index;
    tmr_next   = '0;
    case (state)
      IDLE, WIN, LOSE: begin
        if (start_combo) state_next = START;
      end
      START: begin
        score_next = '0;
        index_next = '0;
        state_next = PAT_OFF;
      end
      PAT_OFF: begin
        tmr_next = tmr + 1'b1;
        if (tmr == CLK_LAST) begin
          tmr_next = '0;
          if (index <= score) begin
            state_next = PAT_SHOW;
          end else begin
            index_next = '0;
            state_next = WAIT_PLAYER;
          end
        end
      end
      PAT_SHOW: begin
        tmr_next = tmr + 1'b1;
        if (tmr == CLK_LAST) begin
          tmr_next   = '0;
          index_next = index + 8'd1;
          state_next = PAT_OFF;
        end
      end
      WAIT_PLAYER: begin
        // Multi-edge presses (including the start combo) never equal a one-hot and lose.
        if (press == exp_oh) begin
          if (index == score) state_next = INCR;
          else                index_next = index + 8'd1;
        end else if (press_any) begin
          state_next = LOSE;
        end
`ifdef SIMON_TIMEOUT_EN
        else if (tmr == TO_LAST) begin
          state_next = LOSE;
        end else begin
          tmr_next = tmr + 1'b1;
        end
`endif
      end
      INCR: begin
        score_next = score + 8'd1;
        index_next = '0;
        if (score + 8'd1 == 8'(GAME_LIMIT)) state_next = WIN;
        else                                state_next = PAT_OFF;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_LED   = '0;
    o_Score = score;
    o_Win   = 1'b0;
    o_Lose  = 1'b0;
    case (state)
      PAT_SHOW:    o_LED = exp_oh;
      WAIT_PLAYER: o_LED = i_Switch;
      WIN: begin
        o_Win   = 1'b1;
        o_Score = 8'(GAME_LIMIT);
        o_LED   = '1;
      end
      LOSE: begin
        o_Lose  = 1'b1;
        o_Score = 8'hFF;
      end
      default: ;
    endcase
  end
endmodule
